// File: rtl/dcl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dcl_pkg : shared types, TYP encodings and width helpers for dcl_seq  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dcl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_EMIT = 2'd2
  } state_e;

  localparam int         TYP_BIT_R3  = 2;
  localparam int         TYP_BIT_OVF = 1;
  localparam logic [3:0] TYP_L1      = 4'b0000;
  localparam logic [3:0] TYP_R3      = 4'(1 << TYP_BIT_R3);
  localparam logic [1:0] MODE_L1     = 2'd2;
  localparam logic [2:0] PAT_EMPTY   = 3'b000;

  function automatic int slot_w(input int addr_w);
    return addr_w + 3;
  endfunction

  function automatic int pay_w(input int maxcl, input int addr_w);
    return maxcl * slot_w(addr_w) + 1;
  endfunction

  function automatic int pkt_w(input int id_w, input int maxcl, input int addr_w);
    return 4 + 2 * id_w + pay_w(maxcl, addr_w);
  endfunction

  function automatic logic [3:0] typ_code(input logic r3, input logic ovf);
    logic [3:0] t;
    t = r3 ? TYP_R3 : TYP_L1;
    t[TYP_BIT_OVF] = ovf;
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dcl_if : event input / readout FIFO bundle of the cluster sequencer  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface dcl_if
  import dcl_pkg::*;
#(
  parameter int NSTRIP = 256,
  parameter int ADDR_W = 8,
  parameter int MAXCL  = 3,
  parameter int ID_W   = 8
);
  localparam int PKT_W = pkt_w(ID_W, MAXCL, ADDR_W);

  logic                     start;
  logic [1:0]               mode;
  logic [2:0]               nbpacket;
  logic [NSTRIP+2*ID_W-1:0] datain;
  logic                     fifo_full;
  logic                     push;
  logic [PKT_W-1:0]         packet;
  logic                     busy;
  logic                     trig_lost;

  modport master (
    output start, mode, nbpacket, datain, fifo_full,
    input  push, packet, busy, trig_lost
  );

  modport slave (
    input  start, mode, nbpacket, datain, fifo_full,
    output push, packet, busy, trig_lost
  );

endinterface
`default_nettype wire

// File: rtl/dcl_prienc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dcl_prienc : lowest-set-bit priority encoder with valid flag         |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dcl_prienc #(
  parameter int NSTRIP = 256,
  parameter int ADDR_W = 8
) (
  input  wire logic [NSTRIP-1:0] i_vec,
  output logic      [ADDR_W-1:0] o_idx,
  output logic                   o_valid
);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = NSTRIP - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = ADDR_W'(i);
    end
  end

  assign o_valid = |i_vec;

endmodule
`default_nettype wire

// File: rtl/dcl_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dcl_seq : sequential cluster finder, one cluster per cycle, packets  |
// |           of MAXCL slots pushed to the readout FIFO with backpressure|
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dcl_seq
  import dcl_pkg::*;
#(
  parameter int NSTRIP = 256,
  parameter int ADDR_W = 8,
  parameter int MAXCL  = 3,
  parameter int ID_W   = 8
) (
  input wire logic clock,
  input wire logic rst,
  dcl_if.slave     bus
);

  localparam int SLOT_W = slot_w(ADDR_W);
  localparam int PAY_W  = pay_w(MAXCL, ADDR_W);
  localparam int PKT_W  = pkt_w(ID_W, MAXCL, ADDR_W);
  localparam int NSL_W  = $clog2(MAXCL + 1);
  localparam int CNT_W  = 4;
  localparam int EXT_W  = $clog2(NSTRIP + 2);

  localparam logic [SLOT_W-1:0] EMPTY_SLOT = {{ADDR_W{1'b1}}, PAT_EMPTY};
  localparam logic [NSTRIP-1:0] CLR3       = NSTRIP'(3'b111);

  state_e                        state_q, state_d;
  logic [NSTRIP-1:0]             mask_q, mask_d;
  logic [ID_W-1:0]               l0id_q, l0id_d;
  logic [ID_W-1:0]               bcid_q, bcid_d;
  logic                          r3_q, r3_d;
  logic [CNT_W-1:0]              limit_q, limit_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [NSL_W-1:0]              nslot_q, nslot_d;
  logic [MAXCL-1:0][SLOT_W-1:0]  slot_q, slot_d;
  logic                          push_q, push_d;
  logic [PKT_W-1:0]              packet_q, packet_d;
  logic                          trig_lost_q, trig_lost_d;

  logic [ADDR_W-1:0]   w_hit_idx;
  logic                w_hit_vld;
  logic [NSTRIP+1:0]   w_mask_ext;
  logic [EXT_W-1:0]    w_idx_ext;
  logic [2:0]          w_hit_pat;
  logic [NSTRIP-1:0]   w_mask_clr;
  logic                w_limit_hit;
  logic                w_last;
  logic                w_ovf;
  logic [PAY_W-1:0]    w_payload;

  dcl_prienc #(
    .NSTRIP (NSTRIP),
    .ADDR_W (ADDR_W)
  ) u_prienc (
    .i_vec   (mask_q),
    .o_idx   (w_hit_idx),
    .o_valid (w_hit_vld)
  );

  // Two zero guard bits make s+1 / s+2 past the top strip read as empty.
  assign w_mask_ext = {2'b00, mask_q};
  assign w_idx_ext  = EXT_W'(w_hit_idx);
  assign w_hit_pat  = {1'b1, w_mask_ext[w_idx_ext + EXT_W'(1)], w_mask_ext[w_idx_ext + EXT_W'(2)]};
  assign w_mask_clr = mask_q & ~(CLR3 << w_hit_idx);

  assign w_limit_hit = (cnt_q + CNT_W'(1)) == limit_q;
  assign w_last      = (mask_q == '0) || w_limit_hit;
  assign w_ovf       = (mask_q != '0) && w_limit_hit;

  always_comb begin
    w_payload = '0;
    for (int k = 0; k < MAXCL; k++) begin
      w_payload[k*SLOT_W+1 +: SLOT_W] = slot_q[k][2] ? slot_q[k] : EMPTY_SLOT;
    end
    w_payload[0] = w_last;
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    l0id_d      = l0id_q;
    bcid_d      = bcid_q;
    r3_d        = r3_q;
    limit_d     = limit_q;
    cnt_d       = cnt_q;
    nslot_d     = nslot_q;
    slot_d      = slot_q;
    push_d      = 1'b0;
    packet_d    = packet_q;
    trig_lost_d = trig_lost_q | (bus.start & (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mask_d  = bus.datain[NSTRIP-1:0];
          bcid_d  = bus.datain[NSTRIP+ID_W-1 -: ID_W];
          l0id_d  = bus.datain[NSTRIP+2*ID_W-1 -: ID_W];
          r3_d    = (bus.mode != MODE_L1);
          limit_d = (bus.nbpacket == 3'd0) ? CNT_W'(8) : CNT_W'(bus.nbpacket);
          cnt_d   = '0;
          nslot_d = '0;
          slot_d  = '0;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        if (w_hit_vld) begin
          slot_d[nslot_q] = {w_hit_idx, w_hit_pat};
          nslot_d         = nslot_q + NSL_W'(1);
          mask_d          = w_mask_clr;
          if (nslot_d == NSL_W'(MAXCL) || w_mask_clr == '0) state_d = S_EMIT;
        end else begin
          state_d = S_EMIT;
        end
      end

      S_EMIT: begin
        if (!bus.fifo_full) begin
          push_d   = 1'b1;
          packet_d = {typ_code(r3_q, w_ovf), l0id_q, bcid_q, w_payload};
          slot_d   = '0;
          nslot_d  = '0;
          cnt_d    = cnt_q + CNT_W'(1);
          state_d  = w_last ? S_IDLE : S_SCAN;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      l0id_q      <= '0;
      bcid_q      <= '0;
      r3_q        <= 1'b0;
      limit_q     <= '0;
      cnt_q       <= '0;
      nslot_q     <= '0;
      slot_q      <= '0;
      push_q      <= 1'b0;
      packet_q    <= '0;
      trig_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      l0id_q      <= l0id_d;
      bcid_q      <= bcid_d;
      r3_q        <= r3_d;
      limit_q     <= limit_d;
      cnt_q       <= cnt_d;
      nslot_q     <= nslot_d;
      slot_q      <= slot_d;
      push_q      <= push_d;
      packet_q    <= packet_d;
      trig_lost_q <= trig_lost_d;
    end
  end

  assign bus.push      = push_q;
  assign bus.packet    = packet_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.trig_lost = trig_lost_q;

endmodule
`default_nettype wire

// File: tb/tb_dcl_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dcl_seq : directed self-checking bench for dcl_seq                |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dcl_seq;

  localparam int NSTRIP = 256;
  localparam int ADDR_W = 8;
  localparam int MAXCL  = 3;
  localparam int ID_W   = 8;
  localparam logic [10:0] ES = {8'hFF, 3'b000};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcl_if #(.NSTRIP(NSTRIP), .ADDR_W(ADDR_W), .MAXCL(MAXCL), .ID_W(ID_W)) bus ();

  dcl_seq #(.NSTRIP(NSTRIP), .ADDR_W(ADDR_W), .MAXCL(MAXCL), .ID_W(ID_W)) dut (
    .clock (clk),
    .rst   (rst),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] sl(input int a, input logic [2:0] p);
    return {8'(a), p};
  endfunction

  function automatic logic [53:0] mk(input logic [3:0] typ, input logic [7:0] l0, input logic [7:0] bc,
                                     input logic [10:0] s2, input logic [10:0] s1, input logic [10:0] s0,
                                     input logic last);
    return {typ, l0, bc, s2, s1, s0, last};
  endfunction

  // Drives start for one cycle; returns in cycle n+1.
  task automatic start_ev(input logic [255:0] h, input logic [1:0] m,
                          input logic [7:0] l0, input logic [7:0] bc, input logic [2:0] nb);
    bus.datain   = {l0, bc, h};
    bus.mode     = m;
    bus.nbpacket = nb;
    bus.start    = 1'b1;
    tick;
    bus.start    = 1'b0;
  endtask

  task automatic wait_push(input string tag, input int c0, output int c);
    c = c0;
    while (bus.push !== 1'b1 && c < 40) begin
      tick;
      c++;
    end
    if (bus.push !== 1'b1) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic count_push(input int ncyc, output int np);
    np = 0;
    for (int i = 0; i < ncyc; i++) begin
      tick;
      if (bus.push === 1'b1) np++;
    end
  endtask

  initial begin
    logic [255:0] h;
    logic [53:0]  exp_pkt;
    int           c;
    int           np;

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.mode      = 2'd0;
    bus.nbpacket  = 3'd0;
    bus.datain    = '0;
    bus.fifo_full = 1'b0;
    repeat (3) tick;
    rst = 1'b0;
    tick;

    chk("rst_push",  64'(bus.push),      64'd0);
    chk("rst_pkt",   64'(bus.packet),    64'd0);
    chk("rst_busy",  64'(bus.busy),      64'd0);
    chk("rst_lost",  64'(bus.trig_lost), 64'd0);

    // two isolated hits, L1 type
    h = '0; h[5] = 1'b1; h[9] = 1'b1;
    start_ev(h, 2'd2, 8'h3A, 8'h11, 3'd0);
    chk("t2_busy", 64'(bus.busy), 64'd1);
    wait_push("t2", 1, c);
    exp_pkt = mk(4'b0000, 8'h3A, 8'h11, ES, sl(9, 3'b100), sl(5, 3'b100), 1'b1);
    chk("t2_lat",  64'(c), 64'd4);
    chk("t2_pkt",  64'(bus.packet), 64'(exp_pkt));
    chk("t2_busy_end", 64'(bus.busy), 64'd0);
    tick;
    chk("t2_push_1cyc", 64'(bus.push), 64'd0);
    chk("t2_pkt_hold",  64'(bus.packet), 64'(exp_pkt));
    tick;

    // run 10..16 split into 3-strip clusters, R3 type
    h = '0;
    for (int i = 10; i <= 16; i++) h[i] = 1'b1;
    start_ev(h, 2'd0, 8'h55, 8'hAA, 3'd0);
    wait_push("t3", 1, c);
    chk("t3_lat", 64'(c), 64'd5);
    chk("t3_pkt", 64'(bus.packet),
        64'(mk(4'b0100, 8'h55, 8'hAA, sl(16, 3'b100), sl(13, 3'b111), sl(10, 3'b111), 1'b1)));
    tick;

    // five clusters -> two packets
    h = '0; h[0] = 1'b1; h[4] = 1'b1; h[8] = 1'b1; h[12] = 1'b1; h[16] = 1'b1;
    start_ev(h, 2'd2, 8'h10, 8'h20, 3'd0);
    wait_push("t4a", 1, c);
    chk("t4_lat1", 64'(c), 64'd5);
    chk("t4_pkt1", 64'(bus.packet),
        64'(mk(4'b0000, 8'h10, 8'h20, sl(8, 3'b100), sl(4, 3'b100), sl(0, 3'b100), 1'b0)));
    chk("t4_busy_mid", 64'(bus.busy), 64'd1);
    tick;
    wait_push("t4b", 1, c);
    chk("t4_lat2", 64'(c), 64'd3);
    chk("t4_pkt2", 64'(bus.packet),
        64'(mk(4'b0000, 8'h10, 8'h20, ES, sl(16, 3'b100), sl(12, 3'b100), 1'b1)));
    tick;

    // packet limit 1 truncates the event
    h = '0; h[0] = 1'b1; h[4] = 1'b1; h[8] = 1'b1; h[12] = 1'b1;
    start_ev(h, 2'd2, 8'h01, 8'h02, 3'd1);
    wait_push("t5", 1, c);
    chk("t5_lat", 64'(c), 64'd5);
    chk("t5_pkt", 64'(bus.packet),
        64'(mk(4'b0010, 8'h01, 8'h02, sl(8, 3'b100), sl(4, 3'b100), sl(0, 3'b100), 1'b1)));
    chk("t5_busy", 64'(bus.busy), 64'd0);
    count_push(10, np);
    chk("t5_no_more", 64'(np), 64'd0);

    // top strip: pattern bits beyond the edge read as zero
    h = '0; h[255] = 1'b1;
    start_ev(h, 2'd1, 8'hFF, 8'h00, 3'd0);
    wait_push("t6", 1, c);
    chk("t6_lat", 64'(c), 64'd3);
    chk("t6_pkt", 64'(bus.packet),
        64'(mk(4'b0100, 8'hFF, 8'h00, ES, ES, sl(255, 3'b100), 1'b1)));
    tick;

    // empty event still yields one packet
    h = '0;
    start_ev(h, 2'd3, 8'h77, 8'h66, 3'd0);
    wait_push("t7", 1, c);
    exp_pkt = mk(4'b0100, 8'h77, 8'h66, ES, ES, ES, 1'b1);
    chk("t7_lat", 64'(c), 64'd3);
    chk("t7_pkt", 64'(bus.packet), 64'(exp_pkt));
    chk("t7_lost", 64'(bus.trig_lost), 64'd0);
    tick;

    // backpressure: EMIT held 5 cycles, second start during the hold is lost
    h = '0; h[5] = 1'b1; h[9] = 1'b1;
    bus.fifo_full = 1'b1;
    start_ev(h, 2'd2, 8'h3A, 8'h11, 3'd0);
    for (int cyc = 1; cyc < 9; cyc++) begin
      bus.start     = (cyc == 4);
      bus.fifo_full = (cyc < 8);
      chk($sformatf("t8_hold_push_c%0d", cyc), 64'(bus.push), 64'd0);
      tick;
    end
    bus.start = 1'b0;
    chk("t8_hold_pkt", 64'(bus.push), 64'd1);
    chk("t8_pkt", 64'(bus.packet),
        64'(mk(4'b0000, 8'h3A, 8'h11, ES, sl(9, 3'b100), sl(5, 3'b100), 1'b1)));
    chk("t8_lost", 64'(bus.trig_lost), 64'd1);
    count_push(10, np);
    chk("t8_no_extra", 64'(np), 64'd0);
    chk("t8_lost_sticky", 64'(bus.trig_lost), 64'd1);

    // reset mid-event aborts without a push
    h = '0; h[0] = 1'b1; h[4] = 1'b1; h[8] = 1'b1; h[12] = 1'b1; h[16] = 1'b1;
    start_ev(h, 2'd2, 8'h10, 8'h20, 3'd0);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("t9_push", 64'(bus.push),      64'd0);
    chk("t9_pkt",  64'(bus.packet),    64'd0);
    chk("t9_busy", 64'(bus.busy),      64'd0);
    chk("t9_lost", 64'(bus.trig_lost), 64'd0);
    count_push(10, np);
    chk("t9_no_push", 64'(np), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
